// File: rtl/sysid_if.sv
// sysid_if: Avalon-MM control-slave bus of the sysid register bank
interface sysid_if;
    logic [2:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        readdatavalid;
    modport master (output address, read, write, writedata, input readdata, readdatavalid);
    modport slave  (input address, read, write, writedata, output readdata, readdatavalid);
endinterface

// File: rtl/sysid_regfile.sv
// sysid_regfile: read-latency-1 Avalon-MM ID/timestamp/caps/scratch bank; SYSID_UPTIME_EN adds the 64-bit uptime counter
module sysid_regfile #(
    parameter logic [31:0] ID_VALUE  = 32'h0000_0000,
    parameter logic [31:0] TIMESTAMP = 32'd1519049163,
    parameter int          SCRATCH_N = 2,
    parameter int          TICK_DIV  = 50000000
) (
    input  logic clock,
    input  logic reset_n,
    sysid_if.slave bus
);
`ifdef SYSID_UPTIME_EN
    localparam logic UP = 1'b1;
`else
    localparam logic UP = 1'b0;
`endif
    localparam logic [31:0] CAPS = {UP, 23'd0, 4'(SCRATCH_N), 4'h2};
    logic [31:0] readdata_q, readdata_d, rdata;
    logic        readdatavalid_q, readdatavalid_d;
    logic [31:0] scratch_q [2];
    logic [31:0] scratch_d [2];
    logic        wr;
`ifdef SYSID_UPTIME_EN
    localparam int PW = $clog2(TICK_DIV);
    logic [PW-1:0] presc_q, presc_d;
    logic [63:0]   uptime_q, uptime_d;
    logic [31:0]   shadow_q, shadow_d;
    logic          wrap;
`endif
    // a read in the same cycle wins over the write
    assign wr = bus.write && !bus.read;
    assign bus.readdata = readdata_q;
    assign bus.readdatavalid = readdatavalid_q;
    always_comb begin
        rdata = '0;
        case (bus.address)
            3'd0: rdata = ID_VALUE;
            3'd1: rdata = TIMESTAMP;
            3'd2: rdata = CAPS;
`ifdef SYSID_UPTIME_EN
            3'd3: rdata = uptime_q[31:0];
            3'd4: rdata = shadow_q;
`endif
            3'd5: rdata = SCRATCH_N > 0 ? scratch_q[0] : '0;
            3'd6: rdata = SCRATCH_N > 1 ? scratch_q[1] : '0;
            default: rdata = '0;
        endcase
        readdata_d = bus.read ? rdata : readdata_q;
        readdatavalid_d = bus.read;
        scratch_d[0] = (wr && bus.address == 3'd5 && SCRATCH_N > 0) ? bus.writedata : scratch_q[0];
        scratch_d[1] = (wr && bus.address == 3'd6 && SCRATCH_N > 1) ? bus.writedata : scratch_q[1];
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            readdata_q      <= '0;
            readdatavalid_q <= 1'b0;
            scratch_q[0]    <= '0;
            scratch_q[1]    <= '0;
        end else begin
            readdata_q      <= readdata_d;
            readdatavalid_q <= readdatavalid_d;
            scratch_q[0]    <= scratch_d[0];
            scratch_q[1]    <= scratch_d[1];
        end
    end
`ifdef SYSID_UPTIME_EN
    // shadow takes the pre-edge high word so {shadow, LO readdata} is one coherent sample
    always_comb begin
        wrap     = presc_q == PW'(TICK_DIV - 1);
        presc_d  = wrap ? '0 : presc_q + 1'b1;
        uptime_d = wrap ? uptime_q + 64'd1 : uptime_q;
        shadow_d = (bus.read && bus.address == 3'd3) ? uptime_q[63:32] : shadow_q;
        if (wr && bus.address == 3'd3) begin
            presc_d  = '0;
            uptime_d = '0;
        end
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            presc_q  <= '0;
            uptime_q <= '0;
            shadow_q <= '0;
        end else begin
            presc_q  <= presc_d;
            uptime_q <= uptime_d;
            shadow_q <= shadow_d;
        end
    end
`endif
endmodule

// File: tb/tb_sysid_regfile.sv
// tb_sysid_regfile: directed checks of the sysid register bank (TICK_DIV=4)
module tb_sysid_regfile;
    localparam logic [31:0] TS = 32'd1519049163;
`ifdef SYSID_UPTIME_EN
    localparam logic [31:0] CAPS = 32'h8000_0022;
`else
    localparam logic [31:0] CAPS = 32'h0000_0022;
`endif
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int checks = 0;
    int failures = 0;
    sysid_if bus ();
    sysid_regfile #(.TICK_DIV(4)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));
    always #5 clock = ~clock;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus.address = a; bus.writedata = d; bus.write = 1'b1; bus.read = 1'b0;
        @(negedge clock);
        bus.write = 1'b0;
    endtask
    task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string tag);
        bus.address = a; bus.read = 1'b1; bus.write = 1'b0;
        @(negedge clock);
        bus.read = 1'b0;
        chk({tag, "_valid"}, 32'(bus.readdatavalid), 32'd1);
        chk(tag, bus.readdata, exp);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
    initial begin
        bus.address = '0; bus.read = 1'b0; bus.write = 1'b0; bus.writedata = '0;
        repeat (3) @(negedge clock);
        chk("reset_rdata", bus.readdata, 32'd0);
        chk("reset_valid", 32'(bus.readdatavalid), 32'd0);
        reset_n = 1'b1;
        @(negedge clock);
        bus.address = 3'd0; bus.read = 1'b1;
        @(negedge clock);
        chk("b2b_id", bus.readdata, 32'd0);
        chk("b2b_id_valid", 32'(bus.readdatavalid), 32'd1);
        bus.address = 3'd1;
        @(negedge clock);
        chk("b2b_ts", bus.readdata, TS);
        chk("b2b_ts_valid", 32'(bus.readdatavalid), 32'd1);
        bus.address = 3'd2;
        @(negedge clock);
        bus.read = 1'b0;
        chk("b2b_caps", bus.readdata, CAPS);
        chk("b2b_caps_valid", 32'(bus.readdatavalid), 32'd1);
        @(negedge clock);
        chk("idle_valid", 32'(bus.readdatavalid), 32'd0);
        chk("idle_hold", bus.readdata, CAPS);
        wr(3'd5, 32'hDEAD_BEEF);
        wr(3'd6, 32'h1234_5678);
        rd(3'd5, 32'hDEAD_BEEF, "scratch0");
        rd(3'd6, 32'h1234_5678, "scratch1");
        wr(3'd1, 32'h0);
        rd(3'd1, TS, "ts_ro");
        wr(3'd7, 32'hFFFF_FFFF);
        rd(3'd7, 32'h0, "reserved");
        bus.address = 3'd5; bus.read = 1'b1; bus.write = 1'b1; bus.writedata = 32'h5;
        @(negedge clock);
        bus.read = 1'b0; bus.write = 1'b0;
        chk("rw_same_old", bus.readdata, 32'hDEAD_BEEF);
        rd(3'd5, 32'hDEAD_BEEF, "rw_same_kept");
`ifdef SYSID_UPTIME_EN
        force dut.uptime_q = 64'h0000_0000_FFFF_FFFF;
        force dut.presc_q = 2'd3;
        #1;
        release dut.uptime_q;
        release dut.presc_q;
        rd(3'd3, 32'hFFFF_FFFF, "wrap_lo");
        rd(3'd4, 32'h0, "wrap_hi");
        rd(3'd3, 32'h0, "carry_lo");
        rd(3'd4, 32'h1, "carry_hi");
        repeat (40) @(negedge clock);
        wr(3'd3, 32'h1234);
        rd(3'd3, 32'h0, "clear_lo");
`else
        repeat (100) @(negedge clock);
        rd(3'd3, 32'h0, "off_lo");
        rd(3'd4, 32'h0, "off_hi");
        wr(3'd3, 32'h1234);
        rd(3'd3, 32'h0, "off_lo_wr");
`endif
        bus.address = 3'd1; bus.read = 1'b1;
        @(posedge clock);
        #1;
        bus.read = 1'b0;
        chk("inflight_valid", 32'(bus.readdatavalid), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(bus.readdatavalid), 32'd0);
        chk("async_rst_rdata", bus.readdata, 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
